// File: rtl/nest_placer.sv
// Setup-phase cursor controller: moves a placement cursor, validates it against an obstacle check
// and issues the one-cycle SET load to the nest. Define NEST_PLACER_WRAP_EN to wrap at bounds instead of saturating.
module nest_placer #(
    parameter int X_BITS       = 10,
    parameter int Y_BITS       = 9,
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int RADIUS       = 8,
    parameter int STEP         = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int CHECK_LAT    = 2
) (
    input  logic              setup_clk,
    input  logic              RESET,
    input  logic              start,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_place,
    input  logic              obstacle_hit,
    output logic [X_BITS-1:0] cursor_x,
    output logic [Y_BITS-1:0] cursor_y,
    output logic              SETUP_PHASE,
    output logic              SET,
    output logic [X_BITS-1:0] nest_x,
    output logic [Y_BITS-1:0] nest_y,
    output logic              placed,
    output logic              reject
);

    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam int CHK_W = $clog2(CHECK_LAT + 1);

    localparam logic [X_BITS:0] X_LO = (X_BITS+1)'(RADIUS);
    localparam logic [X_BITS:0] X_HI = (X_BITS+1)'(X_MAX - RADIUS);
    localparam logic [Y_BITS:0] Y_LO = (Y_BITS+1)'(RADIUS);
    localparam logic [Y_BITS:0] Y_HI = (Y_BITS+1)'(Y_MAX - RADIUS);

    // Value taken when a step would cross the upper (OVER) or lower (UNDER) bound.
`ifdef NEST_PLACER_WRAP_EN
    localparam logic [X_BITS-1:0] X_OVER  = X_BITS'(RADIUS);
    localparam logic [X_BITS-1:0] X_UNDER = X_BITS'(X_MAX - RADIUS);
    localparam logic [Y_BITS-1:0] Y_OVER  = Y_BITS'(RADIUS);
    localparam logic [Y_BITS-1:0] Y_UNDER = Y_BITS'(Y_MAX - RADIUS);
`else
    localparam logic [X_BITS-1:0] X_OVER  = X_BITS'(X_MAX - RADIUS);
    localparam logic [X_BITS-1:0] X_UNDER = X_BITS'(RADIUS);
    localparam logic [Y_BITS-1:0] Y_OVER  = Y_BITS'(Y_MAX - RADIUS);
    localparam logic [Y_BITS-1:0] Y_UNDER = Y_BITS'(RADIUS);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDIT,
        S_CHECK,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [X_BITS-1:0] cur_x_q, cur_x_d, nest_x_q, nest_x_d;
    logic [Y_BITS-1:0] cur_y_q, cur_y_d, nest_y_q, nest_y_d;
    logic              up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d, place_q, place_d;
    logic [RPT_W-1:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [CHK_W-1:0]  chk_q, chk_d;
    logic              reject_q, reject_d;

    logic              place_rise;
    logic              x_inc, x_dec, y_inc, y_dec;
    logic [X_BITS:0]   x_up, x_dn;
    logic [Y_BITS:0]   y_up, y_dn;

    always_comb begin
        up_d       = btn_up;
        down_d     = btn_down;
        left_d     = btn_left;
        right_d    = btn_right;
        place_d    = btn_place;
        place_rise = btn_place & ~place_q;
    end

    // Moves only in EDIT and never in the cycle that requests placement.
    always_comb begin
        x_cnt_d = '0;
        x_inc   = 1'b0;
        x_dec   = 1'b0;
        if (state_q == S_EDIT && !place_rise && (btn_left ^ btn_right)) begin
            if ((btn_right && !right_q) || (btn_left && !left_q) ||
                x_cnt_q == RPT_W'(REPEAT_DELAY)) begin
                x_inc   = btn_right;
                x_dec   = btn_left;
                x_cnt_d = RPT_W'(1);
            end else begin
                x_cnt_d = x_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        y_cnt_d = '0;
        y_inc   = 1'b0;
        y_dec   = 1'b0;
        if (state_q == S_EDIT && !place_rise && (btn_up ^ btn_down)) begin
            if ((btn_down && !down_q) || (btn_up && !up_q) ||
                y_cnt_q == RPT_W'(REPEAT_DELAY)) begin
                y_inc   = btn_down;
                y_dec   = btn_up;
                y_cnt_d = RPT_W'(1);
            end else begin
                y_cnt_d = y_cnt_q + 1'b1;
            end
        end
    end

    // One extra bit so a step below zero shows up in the MSB instead of wrapping.
    always_comb begin
        x_up    = {1'b0, cur_x_q} + (X_BITS+1)'(STEP);
        x_dn    = {1'b0, cur_x_q} - (X_BITS+1)'(STEP);
        y_up    = {1'b0, cur_y_q} + (Y_BITS+1)'(STEP);
        y_dn    = {1'b0, cur_y_q} - (Y_BITS+1)'(STEP);
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (x_inc) begin
            cur_x_d = (x_up > X_HI) ? X_OVER : x_up[X_BITS-1:0];
        end else if (x_dec) begin
            cur_x_d = (x_dn[X_BITS] || x_dn < X_LO) ? X_UNDER : x_dn[X_BITS-1:0];
        end
        if (y_inc) begin
            cur_y_d = (y_up > Y_HI) ? Y_OVER : y_up[Y_BITS-1:0];
        end else if (y_dec) begin
            cur_y_d = (y_dn[Y_BITS] || y_dn < Y_LO) ? Y_UNDER : y_dn[Y_BITS-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        chk_d    = '0;
        reject_d = 1'b0;
        nest_x_d = nest_x_q;
        nest_y_d = nest_y_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_EDIT;
            end
            S_EDIT: begin
                if (place_rise) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (chk_q == CHK_W'(CHECK_LAT - 1)) begin
                    if (obstacle_hit) begin
                        state_d  = S_EDIT;
                        reject_d = 1'b1;
                    end else begin
                        state_d  = S_COMMIT;
                        nest_x_d = cur_x_q;
                        nest_y_d = cur_y_q;
                    end
                end else begin
                    chk_d = chk_q + 1'b1;
                end
            end
            S_COMMIT: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge setup_clk or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cur_x_q  <= X_BITS'(X_MAX / 2);
            cur_y_q  <= Y_BITS'(Y_MAX / 2);
            nest_x_q <= '0;
            nest_y_q <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            place_q  <= 1'b0;
            x_cnt_q  <= '0;
            y_cnt_q  <= '0;
            chk_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            nest_x_q <= nest_x_d;
            nest_y_q <= nest_y_d;
            up_q     <= up_d;
            down_q   <= down_d;
            left_q   <= left_d;
            right_q  <= right_d;
            place_q  <= place_d;
            x_cnt_q  <= x_cnt_d;
            y_cnt_q  <= y_cnt_d;
            chk_q    <= chk_d;
            reject_q <= reject_d;
        end
    end

    assign cursor_x    = cur_x_q;
    assign cursor_y    = cur_y_q;
    assign nest_x      = nest_x_q;
    assign nest_y      = nest_y_q;
    assign SETUP_PHASE = (state_q == S_EDIT) || (state_q == S_CHECK) || (state_q == S_COMMIT);
    assign SET         = (state_q == S_COMMIT);
    assign placed      = (state_q == S_DONE);
    assign reject      = reject_q;

endmodule

// File: tb/tb_nest_placer.sv
// Scoreboard bench for nest_placer: stimulus queues each expected output change with its cycle,
// a negedge monitor pops and compares whenever the visible outputs change.
module tb_nest_placer;

    logic       setup_clk = 1'b0;
    logic       RESET = 1'b1;
    logic       start = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_place = 1'b0;
    logic       obstacle_hit = 1'b0;
    logic [9:0] cursor_x, nest_x;
    logic [8:0] cursor_y, nest_y;
    logic       SETUP_PHASE, SET, placed, reject;

    nest_placer #(
        .X_BITS(10), .Y_BITS(9), .X_MAX(639), .Y_MAX(479),
        .RADIUS(8), .STEP(4), .REPEAT_DELAY(16), .CHECK_LAT(2)
    ) dut (
        .setup_clk(setup_clk), .RESET(RESET), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_place(btn_place), .obstacle_hit(obstacle_hit),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .SETUP_PHASE(SETUP_PHASE), .SET(SET),
        .nest_x(nest_x), .nest_y(nest_y), .placed(placed), .reject(reject)
    );

    always #5 setup_clk = ~setup_clk;

    int cyc = 0;
    always @(posedge setup_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       sp;
        logic       set;
        logic       pl;
        logic       rej;
        logic [9:0] nx;
        logic [8:0] ny;
    } snap_t;

    typedef struct {
        snap_t s;
        int    at;
        string tag;
    } exp_t;

    exp_t  exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    nx_e = 0, ny_e = 0;
    snap_t last, cur;
    logic  have_last = 1'b0;

    function automatic snap_t mk(int x, int y, logic sp, logic set, logic pl, logic rej, int nx, int ny);
        snap_t s;
        s.x = 10'(x); s.y = 9'(y); s.sp = sp; s.set = set; s.pl = pl; s.rej = rej;
        s.nx = 10'(nx); s.ny = 9'(ny);
        return s;
    endfunction

    task automatic expect_ev(string tag, int at, int x, int y, logic sp, logic set, logic pl, logic rej);
        exp_t e;
        e.s = mk(x, y, sp, set, pl, rej, nx_e, ny_e);
        e.at = at;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge setup_clk);
        #2;
    endtask

    // which: 0 up, 1 down, 2 left, 3 right
    task automatic set_btn(int which, logic v);
        case (which)
            0: btn_up = v;
            1: btn_down = v;
            2: btn_left = v;
            default: btn_right = v;
        endcase
    endtask

    task automatic tap(int which, int x, int y, string tag);
        set_btn(which, 1'b1);
        expect_ev(tag, cyc + 1, x, y, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_btn(which, 1'b0);
        tick();
    endtask

    always @(negedge setup_clk) begin
        if (RESET) begin
            have_last = 1'b0;
        end else begin
            cur = {cursor_x, cursor_y, SETUP_PHASE, SET, placed, reject, nest_x, nest_y};
            if (!have_last || cur != last) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event cyc=%0d got x=%0d y=%0d sp=%0b set=%0b placed=%0b rej=%0b nest=(%0d,%0d) want no change",
                             cyc, cur.x, cur.y, cur.sp, cur.set, cur.pl, cur.rej, cur.nx, cur.ny);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.s != cur || e.at != cyc) begin
                        miscompares++;
                        $display("FAIL %s got cyc=%0d x=%0d y=%0d sp=%0b set=%0b placed=%0b rej=%0b nest=(%0d,%0d) want cyc=%0d x=%0d y=%0d sp=%0b set=%0b placed=%0b rej=%0b nest=(%0d,%0d)",
                                 e.tag, cyc, cur.x, cur.y, cur.sp, cur.set, cur.pl, cur.rej, cur.nx, cur.ny,
                                 e.at, e.s.x, e.s.y, e.s.sp, e.s.set, e.s.pl, e.s.rej, e.s.nx, e.s.ny);
                    end
                end
            end
            last = cur;
            have_last = 1'b1;
        end
    end

    initial begin
        int c;
        repeat (3) tick();
        expect_ev("reset_state", cyc, 319, 239, 1'b0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        tick();

        start = 1'b1;
        expect_ev("enter_edit", cyc + 1, 319, 239, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        tick();

        tap(3, 323, 239, "tap_right");
        tap(2, 319, 239, "tap_left");
        tap(0, 319, 235, "tap_up");
        tap(1, 319, 239, "tap_down");

        // Held right: steps on the edge, then every 16 cycles.
        set_btn(3, 1'b1);
        c = cyc;
        expect_ev("hold_right0", c + 1, 323, 239, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_ev("hold_right1", c + 17, 327, 239, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_ev("hold_right2", c + 33, 331, 239, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (40) tick();
        set_btn(3, 1'b0);
        tick();

        btn_up = 1'b1;
        btn_down = 1'b1;
        repeat (20) tick();
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick();

        tap(2, 327, 239, "tap_left_a");
        tap(2, 323, 239, "tap_left_b");

        // Rejected placement; the simultaneous right press must be dropped.
        obstacle_hit = 1'b1;
        btn_place = 1'b1;
        set_btn(3, 1'b1);
        c = cyc;
        expect_ev("reject_on", c + 3, 323, 239, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_ev("reject_off", c + 4, 323, 239, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_btn(3, 1'b0);
        repeat (10) tick();
        btn_place = 1'b0;
        obstacle_hit = 1'b0;
        tick();

        btn_place = 1'b1;
        c = cyc;
        nx_e = 323;
        ny_e = 239;
        expect_ev("commit_set", c + 3, 323, 239, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_ev("done", c + 4, 323, 239, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) tick();

        // Re-entry keeps the cursor; the still-held place level must not re-trigger.
        start = 1'b1;
        expect_ev("reenter", cyc + 1, 323, 239, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        repeat (5) tick();
        btn_place = 1'b0;
        tick();

        set_btn(2, 1'b1);
        c = cyc;
        for (int j = 0; j < 78; j++)
            expect_ev("hold_left", c + 1 + 16 * j, 323 - 4 * (j + 1), 239, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef NEST_PLACER_WRAP_EN
        expect_ev("left_wrap", c + 1 + 16 * 78, 631, 239, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_ev("left_after_wrap", c + 1 + 16 * 79, 627, 239, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        expect_ev("left_bound", c + 1 + 16 * 78, 8, 239, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        repeat (1272) tick();
        set_btn(2, 1'b0);
        tick();

        set_btn(1, 1'b1);
        c = cyc;
`ifdef NEST_PLACER_WRAP_EN
        for (int j = 0; j < 58; j++)
            expect_ev("hold_down", c + 1 + 16 * j, 627, 239 + 4 * (j + 1), 1'b1, 1'b0, 1'b0, 1'b0);
        expect_ev("down_wrap", c + 1 + 16 * 58, 627, 8, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        for (int j = 0; j < 58; j++)
            expect_ev("hold_down", c + 1 + 16 * j, 8, 239 + 4 * (j + 1), 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        repeat (936) tick();
        set_btn(1, 1'b0);
        tick();

        // Reset while in CHECK: no SET, full return to reset state.
        btn_place = 1'b1;
        tick();
        RESET = 1'b1;
        repeat (3) tick();
        btn_place = 1'b0;
        nx_e = 0;
        ny_e = 0;
        expect_ev("reset_in_check", cyc, 319, 239, 1'b0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        repeat (3) tick();

        start = 1'b1;
        expect_ev("start_after_reset", cyc + 1, 319, 239, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        repeat (5) tick();

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s got no event want cyc=%0d x=%0d y=%0d", e.tag, e.at, e.s.x, e.s.y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
